// File: rtl/sram_arbiter_pkg.sv
// Shared types and constants for the SRAM port arbiter.
package sram_arbiter_pkg;

    localparam int unsigned ADDR_W      = 16;
    localparam int unsigned DATA_W      = 8;
    localparam int unsigned RD_WAIT_DEF = 1;
    localparam int unsigned WR_WAIT_DEF = 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_e;

    typedef enum logic {
        PORT_CPU = 1'b0,
        PORT_PNL = 1'b1
    } port_e;

    // Transfer latched at grant time and replayed onto the SRAM pins.
    typedef struct packed {
        port_e               port;
        logic                we;
        logic [ADDR_W-1:0]   addr;
        logic [DATA_W-1:0]   wdata;
    } xfer_t;

endpackage

// File: rtl/sram_arbiter_if.sv
// Request/acknowledge bus between one requester and the SRAM arbiter.
interface sram_arbiter_if;
    import sram_arbiter_pkg::*;

    logic               req;
    logic               we;
    logic [ADDR_W-1:0]  addr;
    logic [DATA_W-1:0]  wdata;
    logic [DATA_W-1:0]  rdata;
    logic               ack;

    modport master (output req, we, addr, wdata, input rdata, ack);
    modport slave  (input req, we, addr, wdata, output rdata, ack);

endinterface

// File: rtl/sram_rr_arbiter.sv
// Two-way round-robin grant: on a tie the port not granted last wins.
module sram_rr_arbiter
    import sram_arbiter_pkg::*;
(
    input  logic  clk,
    input  logic  rst_n,
    input  logic  req_c_i,
    input  logic  req_p_i,
    input  logic  upd_i,
    output port_e gnt_port_c
);

    port_e last_q;

    // Grant selection from the current requests and the last winner.
    always_comb begin
        gnt_port_c = PORT_CPU;
        if (req_c_i && req_p_i) begin
            gnt_port_c = (last_q == PORT_PNL) ? PORT_CPU : PORT_PNL;
        end else if (req_p_i) begin
            gnt_port_c = PORT_PNL;
        end
    end

    // Last-grant flop; resets to the panel so the CPU wins the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= PORT_PNL;
        end else if (upd_i) begin
            last_q <= gnt_port_c;
        end
    end

endmodule

// File: rtl/sram_arbiter.sv
// Shares one external SRAM between the CPU bus and the front panel.
module sram_arbiter
    import sram_arbiter_pkg::*;
#(
    parameter int unsigned RD_WAIT = RD_WAIT_DEF,
    parameter int unsigned WR_WAIT = WR_WAIT_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    sram_arbiter_if.slave      cpu,
    sram_arbiter_if.slave      pnl,
    output logic               busy,
    output logic [ADDR_W-1:0]  sram_addr,
    output logic               sram_ce_n,
    output logic               sram_oe_n,
    output logic               sram_we_n,
    output logic               sram_lb_n,
    output logic               sram_ub_n,
    inout  wire  [DATA_W-1:0]  sram_dq
);

    localparam int unsigned MAX_WAIT = (RD_WAIT > WR_WAIT) ? RD_WAIT : WR_WAIT;
    localparam int unsigned CNT_W    = $clog2(MAX_WAIT + 1);

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    xfer_t               xfer_q, xfer_d;
    port_e               gnt_port_c;
    logic                grant_c;
    logic                last_cycle_c;

    logic                busy_q, busy_d;
    logic                ce_n_q, ce_n_d;
    logic                oe_n_q, oe_n_d;
    logic                we_n_q, we_n_d;
    logic                dq_oe_q, dq_oe_d;
    logic                cpu_ack_q, cpu_ack_d;
    logic                pnl_ack_q, pnl_ack_d;
    logic [DATA_W-1:0]   cpu_rdata_q, cpu_rdata_d;
    logic [DATA_W-1:0]   pnl_rdata_q, pnl_rdata_d;

    assign grant_c      = (state_q == ST_IDLE) && (cpu.req || pnl.req);
    assign last_cycle_c = (state_q == ST_ACCESS) && (cnt_q == CNT_W'(1));

    sram_rr_arbiter u_rr (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_c_i    (cpu.req),
        .req_p_i    (pnl.req),
        .upd_i      (grant_c),
        .gnt_port_c (gnt_port_c)
    );

    // State, wait counter and latched transfer registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            xfer_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            xfer_q  <= xfer_d;
        end
    end

    // Next state: grant from IDLE, count down the access, one DONE cycle.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        xfer_d  = xfer_q;
        case (state_q)
            ST_IDLE: begin
                if (grant_c) begin
                    state_d     = ST_ACCESS;
                    xfer_d.port = gnt_port_c;
                    if (gnt_port_c == PORT_CPU) begin
                        xfer_d.we    = cpu.we;
                        xfer_d.addr  = cpu.addr;
                        xfer_d.wdata = cpu.wdata;
                    end else begin
                        xfer_d.we    = pnl.we;
                        xfer_d.addr  = pnl.addr;
                        xfer_d.wdata = pnl.wdata;
                    end
                    cnt_d = xfer_d.we ? CNT_W'(WR_WAIT) : CNT_W'(RD_WAIT);
                end
            end
            ST_ACCESS: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Output next values, derived from the state being entered.
    always_comb begin
        busy_d      = (state_d != ST_IDLE);
        ce_n_d      = (state_d != ST_ACCESS);
        oe_n_d      = !((state_d == ST_ACCESS) && !xfer_d.we);
        we_n_d      = !((state_d == ST_ACCESS) && xfer_d.we);
        dq_oe_d     = ((state_d == ST_ACCESS) || (state_d == ST_DONE)) && xfer_d.we;
        cpu_ack_d   = last_cycle_c && (xfer_q.port == PORT_CPU);
        pnl_ack_d   = last_cycle_c && (xfer_q.port == PORT_PNL);
        cpu_rdata_d = cpu_rdata_q;
        pnl_rdata_d = pnl_rdata_q;
        if (last_cycle_c && !xfer_q.we) begin
            if (xfer_q.port == PORT_CPU) begin
                cpu_rdata_d = sram_dq;
            end else begin
                pnl_rdata_d = sram_dq;
            end
        end
    end

    // Registered outputs; reset releases the bus and drops all strobes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q      <= 1'b0;
            ce_n_q      <= 1'b1;
            oe_n_q      <= 1'b1;
            we_n_q      <= 1'b1;
            dq_oe_q     <= 1'b0;
            cpu_ack_q   <= 1'b0;
            pnl_ack_q   <= 1'b0;
            cpu_rdata_q <= '0;
            pnl_rdata_q <= '0;
        end else begin
            busy_q      <= busy_d;
            ce_n_q      <= ce_n_d;
            oe_n_q      <= oe_n_d;
            we_n_q      <= we_n_d;
            dq_oe_q     <= dq_oe_d;
            cpu_ack_q   <= cpu_ack_d;
            pnl_ack_q   <= pnl_ack_d;
            cpu_rdata_q <= cpu_rdata_d;
            pnl_rdata_q <= pnl_rdata_d;
        end
    end

    assign busy      = busy_q;
    assign sram_addr = xfer_q.addr;
    assign sram_ce_n = ce_n_q;
    assign sram_oe_n = oe_n_q;
    assign sram_we_n = we_n_q;
    assign sram_lb_n = ce_n_q;
    assign sram_ub_n = 1'b1;
    assign sram_dq   = dq_oe_q ? xfer_q.wdata : {DATA_W{1'bz}};
    assign cpu.ack   = cpu_ack_q;
    assign cpu.rdata = cpu_rdata_q;
    assign pnl.ack   = pnl_ack_q;
    assign pnl.rdata = pnl_rdata_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter: default-wait instance plus an RD_WAIT=3 instance.
module tb_sram_arbiter;
    import sram_arbiter_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   passed = 0;

    always #5 clk = ~clk;

    // Default-wait DUT with a 64K x 8 SRAM model.
    sram_arbiter_if cpu_if ();
    sram_arbiter_if pnl_if ();
    logic              busy, ce_n, oe_n, we_n, lb_n, ub_n;
    logic [ADDR_W-1:0] sram_addr;
    wire  [DATA_W-1:0] sram_dq;
    logic [DATA_W-1:0] mem [0:65535];

    sram_arbiter dut (
        .clk(clk), .rst_n(rst_n), .cpu(cpu_if), .pnl(pnl_if), .busy(busy),
        .sram_addr(sram_addr), .sram_ce_n(ce_n), .sram_oe_n(oe_n), .sram_we_n(we_n),
        .sram_lb_n(lb_n), .sram_ub_n(ub_n), .sram_dq(sram_dq)
    );

    assign sram_dq = (!ce_n && !oe_n) ? mem[sram_addr] : 8'hzz;
    always @(posedge clk) if (!ce_n && !we_n) mem[sram_addr] <= sram_dq;

    // RD_WAIT=3 DUT with a ROM-like model: data = 0x3C ^ addr[7:0].
    sram_arbiter_if cpu2_if ();
    sram_arbiter_if pnl2_if ();
    logic              busy2, ce2_n, oe2_n, we2_n, lb2_n, ub2_n;
    logic [ADDR_W-1:0] sram_addr2;
    wire  [DATA_W-1:0] sram_dq2;

    sram_arbiter #(.RD_WAIT(3), .WR_WAIT(1)) dut2 (
        .clk(clk), .rst_n(rst_n), .cpu(cpu2_if), .pnl(pnl2_if), .busy(busy2),
        .sram_addr(sram_addr2), .sram_ce_n(ce2_n), .sram_oe_n(oe2_n), .sram_we_n(we2_n),
        .sram_lb_n(lb2_n), .sram_ub_n(ub2_n), .sram_dq(sram_dq2)
    );

    assign sram_dq2 = (!ce2_n && !oe2_n) ? (8'h3C ^ sram_addr2[7:0]) : 8'hzz;

    task automatic test_reset();
        @(negedge clk);
        checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else passed++;
        checks++; if ({ce_n, oe_n, we_n, lb_n, ub_n} !== 5'b11111)
            $display("FAIL reset_strobes: got %b expected 11111", {ce_n, oe_n, we_n, lb_n, ub_n}); else passed++;
        checks++; if (dut.dq_oe_q !== 1'b0) $display("FAIL reset_dq_released: got %b expected 0", dut.dq_oe_q); else passed++;
        checks++; if (sram_addr !== 16'h0000) $display("FAIL reset_addr: got %h expected 0000", sram_addr); else passed++;
        checks++; if ({cpu_if.ack, pnl_if.ack} !== 2'b00) $display("FAIL reset_acks: got %b expected 00", {cpu_if.ack, pnl_if.ack}); else passed++;
        checks++; if ({cpu_if.rdata, pnl_if.rdata} !== 16'h0000)
            $display("FAIL reset_rdata: got %h expected 0000", {cpu_if.rdata, pnl_if.rdata}); else passed++;
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_cpu_write();
        cpu_if.req = 1'b1; cpu_if.we = 1'b1; cpu_if.addr = 16'h1234; cpu_if.wdata = 8'hA5;
        @(negedge clk);
        checks++; if ({ce_n, oe_n, we_n, lb_n, ub_n} !== 5'b01001)
            $display("FAIL wr_access_strobes: got %b expected 01001", {ce_n, oe_n, we_n, lb_n, ub_n}); else passed++;
        checks++; if (sram_dq !== 8'hA5) $display("FAIL wr_access_dq: got %h expected a5", sram_dq); else passed++;
        checks++; if (sram_addr !== 16'h1234) $display("FAIL wr_access_addr: got %h expected 1234", sram_addr); else passed++;
        checks++; if ({busy, cpu_if.ack} !== 2'b10) $display("FAIL wr_access_busy_ack: got %b expected 10", {busy, cpu_if.ack}); else passed++;
        @(negedge clk);
        checks++; if ({ce_n, oe_n, we_n} !== 3'b111) $display("FAIL wr_done_strobes: got %b expected 111", {ce_n, oe_n, we_n}); else passed++;
        checks++; if ({cpu_if.ack, pnl_if.ack} !== 2'b10) $display("FAIL wr_done_ack: got %b expected 10", {cpu_if.ack, pnl_if.ack}); else passed++;
        checks++; if ({dut.dq_oe_q, sram_dq} !== 9'h1A5) $display("FAIL wr_done_dq_hold: got %h expected 1a5", {dut.dq_oe_q, sram_dq}); else passed++;
        checks++; if (sram_addr !== 16'h1234) $display("FAIL wr_done_addr_hold: got %h expected 1234", sram_addr); else passed++;
        cpu_if.req = 1'b0;
        @(negedge clk);
        checks++; if ({busy, cpu_if.ack, dut.dq_oe_q} !== 3'b000)
            $display("FAIL wr_idle: got %b expected 000", {busy, cpu_if.ack, dut.dq_oe_q}); else passed++;
        checks++; if (mem[16'h1234] !== 8'hA5) $display("FAIL wr_mem: got %h expected a5", mem[16'h1234]); else passed++;
    endtask

    task automatic test_pnl_read();
        pnl_if.req = 1'b1; pnl_if.we = 1'b0; pnl_if.addr = 16'h1234; pnl_if.wdata = 8'h00;
        @(negedge clk);
        checks++; if ({ce_n, oe_n, we_n, dut.dq_oe_q} !== 4'b0010)
            $display("FAIL rd_access: got %b expected 0010", {ce_n, oe_n, we_n, dut.dq_oe_q}); else passed++;
        @(negedge clk);
        checks++; if ({pnl_if.ack, cpu_if.ack} !== 2'b10) $display("FAIL rd_ack: got %b expected 10", {pnl_if.ack, cpu_if.ack}); else passed++;
        checks++; if (pnl_if.rdata !== 8'hA5) $display("FAIL rd_pnl_rdata: got %h expected a5", pnl_if.rdata); else passed++;
        checks++; if (cpu_if.rdata !== 8'h00) $display("FAIL rd_cpu_rdata_untouched: got %h expected 00", cpu_if.rdata); else passed++;
        pnl_if.req = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++; if (pnl_if.rdata !== 8'hA5) $display("FAIL rd_rdata_hold: got %h expected a5", pnl_if.rdata); else passed++;
    endtask

    task automatic test_reset_mid_write();
        cpu_if.req = 1'b1; cpu_if.we = 1'b1; cpu_if.addr = 16'h0BAD; cpu_if.wdata = 8'h5A;
        @(negedge clk);
        checks++; if (we_n !== 1'b0) $display("FAIL mid_pre_we_n: got %b expected 0", we_n); else passed++;
        rst_n = 1'b0; cpu_if.req = 1'b0;
        #1;
        checks++; if ({ce_n, oe_n, we_n, lb_n, ub_n} !== 5'b11111)
            $display("FAIL mid_strobes: got %b expected 11111", {ce_n, oe_n, we_n, lb_n, ub_n}); else passed++;
        checks++; if ({dut.dq_oe_q, busy, cpu_if.ack} !== 3'b000)
            $display("FAIL mid_dq_busy_ack: got %b expected 000", {dut.dq_oe_q, busy, cpu_if.ack}); else passed++;
        @(negedge clk);
        checks++; if (cpu_if.ack !== 1'b0) $display("FAIL mid_no_ack: got %b expected 0", cpu_if.ack); else passed++;
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_tie();
        logic exp_c, exp_p;
        cpu_if.req = 1'b1; cpu_if.we = 1'b1; cpu_if.addr = 16'h0010; cpu_if.wdata = 8'h11;
        pnl_if.req = 1'b1; pnl_if.we = 1'b1; pnl_if.addr = 16'h0020; pnl_if.wdata = 8'h22;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            exp_c = (c == 2) || (c == 8);
            exp_p = (c == 5) || (c == 11);
            checks++; if ({cpu_if.ack, pnl_if.ack} !== {exp_c, exp_p})
                $display("FAIL tie_acks c=%0d: got %b expected %b", c, {cpu_if.ack, pnl_if.ack}, {exp_c, exp_p}); else passed++;
            if (c == 1 || c == 7) begin
                checks++; if (sram_addr !== 16'h0010) $display("FAIL tie_addr_cpu c=%0d: got %h expected 0010", c, sram_addr); else passed++;
            end
            if (c == 4 || c == 10) begin
                checks++; if (sram_addr !== 16'h0020) $display("FAIL tie_addr_pnl c=%0d: got %h expected 0020", c, sram_addr); else passed++;
            end
            checks++; if (!(oe_n || we_n)) $display("FAIL tie_oe_we_overlap c=%0d: got oe_n=%b we_n=%b expected not both 0", c, oe_n, we_n); else passed++;
        end
        cpu_if.req = 1'b0; pnl_if.req = 1'b0;
        @(negedge clk);
        checks++; if ({mem[16'h0010], mem[16'h0020]} !== 16'h1122)
            $display("FAIL tie_mem: got %h expected 1122", {mem[16'h0010], mem[16'h0020]}); else passed++;
    endtask

    task automatic test_rd_wait3();
        logic exp_oe_n, exp_ack;
        cpu2_if.req = 1'b1; cpu2_if.we = 1'b0; cpu2_if.addr = 16'h0042; cpu2_if.wdata = 8'h00;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            exp_oe_n = !(c >= 1 && c <= 3);
            exp_ack  = (c == 4);
            checks++; if ({oe2_n, cpu2_if.ack} !== {exp_oe_n, exp_ack})
                $display("FAIL rw3_oe_ack c=%0d: got %b expected %b", c, {oe2_n, cpu2_if.ack}, {exp_oe_n, exp_ack}); else passed++;
            if (c == 4) begin
                checks++; if (cpu2_if.rdata !== 8'h7E) $display("FAIL rw3_rdata: got %h expected 7e", cpu2_if.rdata); else passed++;
                cpu2_if.req = 1'b0;
            end
        end
    endtask

    task automatic test_held();
        logic exp_ack, exp_busy;
        cpu_if.req = 1'b1; cpu_if.we = 1'b0; cpu_if.addr = 16'h0010; cpu_if.wdata = 8'h00;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            exp_ack  = (c == 2) || (c == 5) || (c == 8);
            exp_busy = !((c % 3) == 0) && (c <= 8);
            checks++; if ({busy, cpu_if.ack} !== {exp_busy, exp_ack})
                $display("FAIL held_busy_ack c=%0d: got %b expected %b", c, {busy, cpu_if.ack}, {exp_busy, exp_ack}); else passed++;
            if (exp_ack) begin
                checks++; if (cpu_if.rdata !== 8'h11) $display("FAIL held_rdata c=%0d: got %h expected 11", c, cpu_if.rdata); else passed++;
            end
            if (c == 8) cpu_if.req = 1'b0;
        end
    endtask

    initial begin
        cpu_if.req = 1'b0;  cpu_if.we = 1'b0;  cpu_if.addr = '0;  cpu_if.wdata = '0;
        pnl_if.req = 1'b0;  pnl_if.we = 1'b0;  pnl_if.addr = '0;  pnl_if.wdata = '0;
        cpu2_if.req = 1'b0; cpu2_if.we = 1'b0; cpu2_if.addr = '0; cpu2_if.wdata = '0;
        pnl2_if.req = 1'b0; pnl2_if.we = 1'b0; pnl2_if.addr = '0; pnl2_if.wdata = '0;
        test_reset();
        test_cpu_write();
        test_pnl_read();
        test_reset_mid_write();
        test_tie();
        test_rd_wait3();
        test_held();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
